hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V core.
- Decides every cycle whether the PC, the IF/ID register, ID/EX and the EX/MEM/WB stages advance, stall, bubble or flush.
- Drives the IF/ID register's Write_i and flush_i inputs, the PC write enable and the ID/EX bubble mux.
- Sequences multi-cycle data-memory waits with a small FSM, a wait counter and a timeout.

Parameters:
- MAX_WAIT, 16: maximum MEM_WAIT cycles before the block declares a timeout error.
- CNT_W, 5: width of the internal wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  synchronous, active-low reset.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rd_i  in  5  destination register of the instruction in EX.
- ifid_rs1_i  in  5  rs1 of the instruction in ID.
- ifid_rs2_i  in  5  rs2 of the instruction in ID.
- ifid_uses_rs2_i  in  1  ID instruction reads rs2.
- branch_taken_i  in  1  branch resolved taken in ID.
- mem_req_i  in  1  MEM stage issues a data access this cycle.
- mem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable (drives Write_i).
- ifid_flush_o  out  1  IF/ID clear (drives flush_i).
- idex_bubble_o  out  1  insert NOP control into ID/EX.
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- err_o  out  1  sticky memory-timeout flag.
- state_o  out  2  FSM state: RUN=0, MEM_WAIT=1, ERR=2.

Behaviour:
- Registered state: FSM state, wait_cnt[CNT_W-1:0], err flag. All outputs except err_o and state_o are combinational from state and inputs, so a stall takes effect in the same cycle.
- Reset (rst_i=0 at a rising edge): state<=RUN, wait_cnt<=0, err<=0.
- Outputs while rst_i=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0.
- Reset mid-MEM_WAIT or in ERR returns to RUN at the next edge.
- Load-use hazard (luh) = idex_memread_i & (idex_rd_i!=0) & ((idex_rd_i==ifid_rs1_i) | (ifid_uses_rs2_i & idex_rd_i==ifid_rs2_i)).
- Memory stall (mst) = mem_req_i & ~mem_ready_i.
- RUN, priority mst > luh > branch > normal:
  - mst: pc_write=0, ifid_write=0, flush=0, bubble=0, hold=1; next state MEM_WAIT, wait_cnt<=1.
  - luh: pc_write=0, ifid_write=0, bubble=1, hold=0, flush=0. Flush stays 0 even if branch_taken_i=1, because the branch re-resolves next cycle with forwarded data.
  - branch_taken_i: pc_write=1, ifid_write=1, flush=1, bubble=0, hold=0. Flush dominates write inside IF/ID.
  - normal: pc_write=1, ifid_write=1, flush=0, bubble=0, hold=0.
  - mem_req_i=1 with mem_ready_i=1 in the same cycle is a single-cycle hit: no stall.
- MEM_WAIT:
  - mem_ready_i=0: full freeze (pc_write=0, ifid_write=0, hold=1, flush=0, bubble=0); wait_cnt<=wait_cnt+1.
  - wait_cnt==MAX_WAIT-1 with mem_ready_i=0: next state ERR, err<=1.
  - mem_ready_i=1: hold=0; remaining outputs use RUN rules for luh and branch, ignoring mst; next state RUN, wait_cnt<=0.
  - All ID-stage inputs are stable during a freeze; branch_taken_i seen during a freeze is ignored until release.
- ERR: full freeze, err_o=1, sticky until reset; mem_ready_i is ignored.
- err_o=err; state_o=state encoding. Unused encoding 3 is treated as ERR.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt_o[31:0] (cycles with luh applied), flush_cnt_o[31:0] (cycles with ifid_flush_o=1 outside reset) and memwait_cnt_o[31:0] (cycles in MEM_WAIT with mem_ready_i=0). All are saturating at 32'hFFFFFFFF and cleared by reset.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Load-use: idex_memread=1, rd=5, rs1=5 for one cycle -> pc_write=0, ifid_write=0, bubble=1 that cycle. With memread=0 the next cycle -> normal outputs.
- rd=0 load-use: idex_memread=1, rd=0, rs1=0 -> no stall, normal outputs.
- Branch: branch_taken=1, no hazard -> flush=1, pc_write=1. Same cycle plus luh (rd=rs2=7, uses_rs2=1) -> flush=0, bubble=1.
- Memory wait: mem_req=1, ready=0 for 3 cycles, then ready=1 -> hold=1 for 3 cycles, state_o 1,1,1, then hold=0 and state_o=0 on the next cycle.
- Timeout with MAX_WAIT=4: mem_req=1, ready held 0 -> err_o=1 and state_o=2 after the 4th wait cycle. Later ready=1 leaves the block frozen; rst_i=0 for one edge -> err_o=0, state_o=0.
- Reset mid-wait: rst_i=0 during MEM_WAIT -> outputs flush=1, bubble=1, pc_write=0 while low; RUN after release. With HAZARD_PERF_EN, the counters read 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline control for the 5-stage core.
// Decides each cycle whether PC, IF/ID, ID/EX and the back end advance,
// stall, bubble or flush, and sequences multi-cycle data-memory waits
// (RUN -> MEM_WAIT -> RUN, or ERR on timeout).
// Optional build macro HAZARD_PERF_EN adds saturating performance counters.
// CNT_W must satisfy 2**CNT_W > MAX_WAIT.
module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rd_i,
    input  logic [4:0]  ifid_rs1_i,
    input  logic [4:0]  ifid_rs2_i,
    input  logic        ifid_uses_rs2_i,
    input  logic        branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        pipe_hold_o,
    output logic        err_o,
    output logic [1:0]  state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] memwait_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // One bundle of per-cycle pipeline control decisions.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_LUH    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b0, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, pipe_hold: 1'b1};
    localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, pipe_hold: 1'b0};

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             err, err_nxt;
    logic             luh, mst;
    ctrl_t            id_ctrl, ctrl;

    // Hazard detection; x0 never creates a dependency.
    always_comb begin
        luh = idex_memread_i && (idex_rd_i != 5'd0) &&
              ((idex_rd_i == ifid_rs1_i) ||
               (ifid_uses_rs2_i && (idex_rd_i == ifid_rs2_i)));
        mst = mem_req_i && !mem_ready_i;
    end

    // ID-stage decision ignoring memory stalls: a load-use stall suppresses
    // the branch flush because the branch re-resolves with forwarded data.
    always_comb begin
        id_ctrl = CTRL_NORMAL;
        if (luh)
            id_ctrl = CTRL_LUH;
        else if (branch_taken_i)
            id_ctrl = CTRL_BRANCH;
    end

    // Next-state and output decode; reset forces the flush/bubble pattern.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err;
        ctrl         = CTRL_NORMAL;
        case (state)
            ST_RUN: begin
                if (mst) begin
                    ctrl         = CTRL_FREEZE;
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = CNT_ONE;
                end else begin
                    ctrl = id_ctrl;
                end
            end
            ST_WAIT: begin
                if (mem_ready_i) begin
                    ctrl         = id_ctrl;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    ctrl         = CTRL_FREEZE;
                    wait_cnt_nxt = wait_cnt + CNT_ONE;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ST_ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                // ERR and the unused encoding: frozen until reset.
                ctrl      = CTRL_FREEZE;
                state_nxt = ST_ERR;
                err_nxt   = 1'b1;
            end
        endcase
        if (!rst_i)
            ctrl = CTRL_RESET;
    end

    // State, wait counter and sticky error register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err      <= err_nxt;
        end
    end

    assign pc_write_o    = ctrl.pc_write;
    assign ifid_write_o  = ctrl.ifid_write;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_bubble_o = ctrl.idex_bubble;
    assign pipe_hold_o   = ctrl.pipe_hold;
    assign err_o         = err;
    assign state_o       = state;

`ifdef HAZARD_PERF_EN
    logic luh_applied;
    logic memwait_cyc;

    // A load-use stall is applied only when the ID decision reaches the outputs.
    always_comb begin
        luh_applied = luh && (((state == ST_RUN) && !mst) ||
                              ((state == ST_WAIT) && mem_ready_i));
        memwait_cyc = (state == ST_WAIT) && !mem_ready_i;
    end

    // Saturating event counters; reset clears them, so reset cycles never count.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
            memwait_cnt_o <= '0;
        end else begin
            if (luh_applied && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (ctrl.ifid_flush && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 32'd1;
            if (memwait_cyc && (memwait_cnt_o != '1))
                memwait_cnt_o <= memwait_cnt_o + 32'd1;
        end
    end
`endif

endmodule
